// File: rtl/red_pitaya_exp_filter.sv
`default_nettype none
// ============================================================================
//  Module      : red_pitaya_exp_filter
//  Description : Conditioning stage for the expansion-connector pad inputs.
//                Each pad bit passes through a 2-flop synchroniser and a
//                programmable-length debouncer. The clean levels go on to
//                housekeeping. Rising and falling edges of the clean levels
//                are captured as sticky write-1-to-clear flags, and the
//                flags drive a registered level interrupt. The block has its
//                own register window on the system bus.
//  Ports       : clk_i / rstn_i           clock, synchronous active-low reset
//                exp_p_raw_i/exp_n_raw_i  asynchronous pad inputs
//                exp_p_dat_o/exp_n_dat_o  debounced levels to housekeeping
//                irq_o                    registered interrupt, active high
//                sys_*                    system bus slave (1-cycle ack)
//  Revision    : 1.0  initial release
// ============================================================================
module red_pitaya_exp_filter #(
  parameter int          DWE     = 8,
  parameter int          DEB_W   = 16,
  parameter int unsigned DEB_RST = 125
) (
  input  logic             clk_i,
  input  logic             rstn_i,
  input  logic [DWE-1:0]   exp_p_raw_i,
  input  logic [DWE-1:0]   exp_n_raw_i,
  output logic [DWE-1:0]   exp_p_dat_o,
  output logic [DWE-1:0]   exp_n_dat_o,
  output logic             irq_o,
  input  logic [31:0]      sys_addr,
  input  logic [31:0]      sys_wdata,
  input  logic             sys_wen,
  input  logic             sys_ren,
  output logic [31:0]      sys_rdata,
  output logic             sys_err,
  output logic             sys_ack
);

  localparam int NB = 2 * DWE;
  localparam logic [DEB_W-1:0] DEB_RST_V = DEB_W'(DEB_RST);

  localparam logic [19:0] ADDR_DEB_LEN = 20'h00000;
  localparam logic [19:0] ADDR_RISE_EN = 20'h00004;
  localparam logic [19:0] ADDR_FALL_EN = 20'h00008;
  localparam logic [19:0] ADDR_RISE_ST = 20'h0000C;
  localparam logic [19:0] ADDR_FALL_ST = 20'h00010;
  localparam logic [19:0] ADDR_IRQ_EN  = 20'h00014;
  localparam logic [19:0] ADDR_LEVEL   = 20'h00018;
  localparam logic [19:0] ADDR_EDGE    = 20'h0001C;

  logic [NB-1:0]    sync_1;
  logic [NB-1:0]    sync_2;
  logic [NB-1:0]    filt;
  logic [NB-1:0]    filt_d;
  logic [DEB_W-1:0] deb_len;
  logic [DEB_W-1:0] deb_lm1;
  logic [NB-1:0]    rise_en;
  logic [NB-1:0]    fall_en;
  logic [NB-1:0]    rise_st;
  logic [NB-1:0]    fall_st;
  logic             irq_en;
  logic [31:0]      edge_cnt;
  logic [NB-1:0]    rise_ev;
  logic [NB-1:0]    fall_ev;
  logic [NB-1:0]    rise_clr;
  logic [NB-1:0]    fall_clr;
  logic [19:0]      addr;

  assign addr = sys_addr[19:0];

  // Synchroniser over the concatenated {n,p} pad vector
  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      sync_1 <= '0;
      sync_2 <= '0;
    end else begin
      sync_1 <= {exp_n_raw_i, exp_p_raw_i};
      sync_2 <= sync_1;
    end
  end

  // Terminal count L-1 with DEB_LEN=0 treated as a length of 1
  assign deb_lm1 = (deb_len == '0) ? '0 : deb_len - 1'b1;

  // Per-bit debouncer. The >= compare means a shortened DEB_LEN takes
  // effect immediately even when a counter is already past the new limit.
  for (genvar i = 0; i < NB; i++) begin : g_deb
    logic [DEB_W-1:0] cnt;
    logic             lvl;

    always_ff @(posedge clk_i) begin
      if (!rstn_i) begin
        cnt <= '0;
        lvl <= 1'b0;
      end else if (sync_2[i] != lvl) begin
        if (cnt >= deb_lm1) begin
          lvl <= sync_2[i];
          cnt <= '0;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end else begin
        cnt <= '0;
      end
    end

    assign filt[i] = lvl;
  end

  assign exp_p_dat_o = filt[DWE-1:0];
  assign exp_n_dat_o = filt[NB-1:DWE];

  assign rise_ev  = filt & ~filt_d & rise_en;
  assign fall_ev  = ~filt & filt_d & fall_en;
  assign rise_clr = (sys_wen && addr == ADDR_RISE_ST) ? sys_wdata[NB-1:0] : '0;
  assign fall_clr = (sys_wen && addr == ADDR_FALL_ST) ? sys_wdata[NB-1:0] : '0;

  // Control registers, sticky flags, edge counter and interrupt
  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      filt_d   <= '0;
      deb_len  <= DEB_RST_V;
      rise_en  <= '0;
      fall_en  <= '0;
      rise_st  <= '0;
      fall_st  <= '0;
      irq_en   <= 1'b0;
      edge_cnt <= '0;
      irq_o    <= 1'b0;
    end else begin
      filt_d <= filt;

      if (sys_wen && addr == ADDR_DEB_LEN) deb_len <= sys_wdata[DEB_W-1:0];
      if (sys_wen && addr == ADDR_RISE_EN) rise_en <= sys_wdata[NB-1:0];
      if (sys_wen && addr == ADDR_FALL_EN) fall_en <= sys_wdata[NB-1:0];
      if (sys_wen && addr == ADDR_IRQ_EN)  irq_en  <= sys_wdata[0];

      // A new event on a bit being cleared in the same cycle survives
      rise_st <= (rise_st & ~rise_clr) | rise_ev;
      fall_st <= (fall_st & ~fall_clr) | fall_ev;

      if (sys_wen && addr == ADDR_EDGE) begin
        edge_cnt <= '0;
      end else if (|(rise_ev | fall_ev)) begin
        edge_cnt <= edge_cnt + 32'd1;
      end

      irq_o <= irq_en & |(rise_st | fall_st);
    end
  end

  // Bus response: every access is acknowledged one cycle later
  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      sys_ack   <= 1'b0;
      sys_err   <= 1'b0;
      sys_rdata <= '0;
    end else begin
      sys_ack <= sys_wen | sys_ren;
      sys_err <= 1'b0;
      if (sys_ren) begin
        case (addr)
          ADDR_DEB_LEN: sys_rdata <= 32'(deb_len);
          ADDR_RISE_EN: sys_rdata <= 32'(rise_en);
          ADDR_FALL_EN: sys_rdata <= 32'(fall_en);
          ADDR_RISE_ST: sys_rdata <= 32'(rise_st);
          ADDR_FALL_ST: sys_rdata <= 32'(fall_st);
          ADDR_IRQ_EN:  sys_rdata <= {31'd0, irq_en};
          ADDR_LEVEL:   sys_rdata <= 32'(filt);
          ADDR_EDGE:    sys_rdata <= edge_cnt;
          default:      sys_rdata <= '0;
        endcase
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_red_pitaya_exp_filter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_red_pitaya_exp_filter
//  Description : Directed self-checking bench for red_pitaya_exp_filter.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_red_pitaya_exp_filter;

  logic        clk;
  logic        rstn;
  logic [7:0]  p_raw;
  logic [7:0]  n_raw;
  logic [7:0]  p_dat;
  logic [7:0]  n_dat;
  logic        irq;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        wen;
  logic        ren;
  logic [31:0] rdata;
  logic        err;
  logic        ack;

  int checks;
  int failures;

  red_pitaya_exp_filter #(
    .DWE     (8),
    .DEB_W   (16),
    .DEB_RST (125)
  ) dut (
    .clk_i       (clk),
    .rstn_i      (rstn),
    .exp_p_raw_i (p_raw),
    .exp_n_raw_i (n_raw),
    .exp_p_dat_o (p_dat),
    .exp_n_dat_o (n_dat),
    .irq_o       (irq),
    .sys_addr    (addr),
    .sys_wdata   (wdata),
    .sys_wen     (wen),
    .sys_ren     (ren),
    .sys_rdata   (rdata),
    .sys_err     (err),
    .sys_ack     (ack)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    if (obs !== exp_v) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp_v);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
    addr  = a;
    wdata = d;
    wen   = 1'b1;
    tick(1);
    wen   = 1'b0;
    check("wr_ack", {31'd0, ack}, 32'd1);
  endtask

  task automatic bus_read(input logic [31:0] a, output logic [31:0] d);
    addr = a;
    ren  = 1'b1;
    tick(1);
    ren  = 1'b0;
    check("rd_ack", {31'd0, ack}, 32'd1);
    check("rd_err", {31'd0, err}, 32'd0);
    d = rdata;
  endtask

  logic [31:0] d;
  logic        seen;

  initial begin
    checks   = 0;
    failures = 0;
    rstn  = 1'b0;
    p_raw = '0;
    n_raw = '0;
    addr  = '0;
    wdata = '0;
    wen   = 1'b0;
    ren   = 1'b0;
    tick(2);
    check("rst_p_dat", {24'd0, p_dat}, 32'd0);
    check("rst_n_dat", {24'd0, n_dat}, 32'd0);
    check("rst_irq",   {31'd0, irq},   32'd0);
    check("rst_ack",   {31'd0, ack},   32'd0);
    check("rst_rdata", rdata,          32'd0);
    rstn = 1'b1;
    tick(1);
    bus_read(32'h00, d); check("rst_deb_len", d, 32'd125);
    bus_read(32'h04, d); check("rst_rise_en", d, 32'd0);
    bus_read(32'h14, d); check("rst_irq_en",  d, 32'd0);

    // Basic rising edge: 2 sync + 4 debounce cycles, flag, irq, W1C
    bus_write(32'h00, 32'd4);
    bus_write(32'h04, 32'h0001);
    bus_write(32'h14, 32'h1);
    p_raw[0] = 1'b1;
    tick(5);
    check("t1_dat_early", {24'd0, p_dat}, 32'h00);
    tick(1);
    check("t1_dat_6", {24'd0, p_dat}, 32'h01);
    tick(1);
    check("t1_irq_7", {31'd0, irq}, 32'd0);
    bus_read(32'h0C, d);
    check("t1_rise_st", d, 32'h0001);
    check("t1_irq_8", {31'd0, irq}, 32'd1);
    bus_write(32'h0C, 32'h0001);
    check("t1_irq_clr1", {31'd0, irq}, 32'd1);
    tick(1);
    check("t1_irq_clr2", {31'd0, irq}, 32'd0);
    bus_read(32'h1C, d);
    check("t1_edge_cnt", d, 32'd1);

    // Short glitch on n[2] is rejected
    bus_write(32'h04, 32'h0401);
    n_raw[2] = 1'b1;
    tick(3);
    n_raw[2] = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick(1);
      seen |= n_dat[2];
    end
    check("t2_glitch_dat", {31'd0, seen}, 32'd0);
    bus_read(32'h0C, d);
    check("t2_rise_st", d, 32'd0);
    check("t2_irq", {31'd0, irq}, 32'd0);

    // All pads fall together: one edge event
    p_raw = 8'hFF;
    n_raw = 8'hFF;
    tick(8);
    bus_read(32'h18, d);
    check("t3_level_hi", d, 32'hFFFF);
    bus_write(32'h04, 32'h0);
    bus_write(32'h0C, 32'hFFFF);
    bus_write(32'h08, 32'hFFFF);
    bus_write(32'h1C, 32'h1234);
    p_raw = 8'h00;
    n_raw = 8'h00;
    tick(8);
    bus_read(32'h10, d); check("t3_fall_st", d, 32'hFFFF);
    bus_read(32'h1C, d); check("t3_edge_cnt", d, 32'd1);
    bus_read(32'h18, d); check("t3_level_lo", d, 32'h0);
    check("t3_irq", {31'd0, irq}, 32'd1);
    bus_write(32'h10, 32'hFFFF);
    bus_write(32'h08, 32'h0);
    tick(1);
    check("t3_irq_clr", {31'd0, irq}, 32'd0);

    // W1C in the same cycle as a new rise: set wins
    bus_write(32'h04, 32'h0001);
    p_raw[0] = 1'b1;
    tick(8);
    p_raw[0] = 1'b0;
    tick(8);
    check("t4_irq_pre", {31'd0, irq}, 32'd1);
    p_raw[0] = 1'b1;
    tick(6);
    bus_write(32'h0C, 32'h0001);
    bus_read(32'h0C, d);
    check("t4_set_wins", d, 32'h0001);
    check("t4_irq", {31'd0, irq}, 32'd1);
    bus_write(32'h04, 32'h0);
    bus_read(32'h0C, d);
    check("t4_kept_after_disable", d, 32'h0001);
    bus_write(32'h0C, 32'h0001);

    // DEB_LEN=0 behaves as 1: 3-cycle latency
    bus_write(32'h00, 32'd0);
    p_raw[1] = 1'b1;
    tick(2);
    check("t5_len0_early", {31'd0, p_dat[1]}, 32'd0);
    tick(1);
    check("t5_len0_3", {31'd0, p_dat[1]}, 32'd1);

    // DEB_LEN=1000: 999-cycle pulse rejected, 1000-cycle pulse accepted
    bus_write(32'h00, 32'd1000);
    p_raw[2] = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 999; i++) begin
      tick(1);
      seen |= p_dat[2];
    end
    p_raw[2] = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick(1);
      seen |= p_dat[2];
    end
    check("t5_999_reject", {31'd0, seen}, 32'd0);
    p_raw[3] = 1'b1;
    tick(1000);
    p_raw[3] = 1'b0;
    tick(1);
    check("t5_1000_early", {31'd0, p_dat[3]}, 32'd0);
    tick(1);
    check("t5_1000_accept", {31'd0, p_dat[3]}, 32'd1);

    // Shortening DEB_LEN below a running count toggles on the next cycle
    p_raw[4] = 1'b1;
    tick(100);
    bus_write(32'h00, 32'd4);
    check("t5_shrink_early", {31'd0, p_dat[4]}, 32'd0);
    tick(1);
    check("t5_shrink", {31'd0, p_dat[4]}, 32'd1);

    // Reset mid-debounce with a pending interrupt
    bus_write(32'h00, 32'd1);
    bus_write(32'h04, 32'h0040);
    p_raw[6] = 1'b1;
    tick(5);
    check("t6_irq_pre", {31'd0, irq}, 32'd1);
    bus_write(32'h00, 32'd50);
    p_raw[5] = 1'b1;
    tick(10);
    rstn = 1'b0;
    tick(1);
    check("t6_p_dat", {24'd0, p_dat}, 32'd0);
    check("t6_n_dat", {24'd0, n_dat}, 32'd0);
    check("t6_irq",   {31'd0, irq},   32'd0);
    check("t6_ack",   {31'd0, ack},   32'd0);
    check("t6_rdata", rdata,          32'd0);
    check("t6_err",   {31'd0, err},   32'd0);
    rstn = 1'b1;
    bus_read(32'h00, d); check("t6_deb_len", d, 32'd125);
    bus_read(32'h40, d); check("t6_unmapped", d, 32'd0);
    tick(1);
    check("t6_ack_idle", {31'd0, ack}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
